adc_acq_sm_multi: RTL and testbench



---
 rtl/adc_acq_pkg.sv | 54 +++++
 rtl/adc_acq_sync.sv | 26 ++
 rtl/adc_acq_sm_multi.sv | 148 ++++++++++++++
 tb/tb_adc_acq_sm_multi.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_acq_pkg.sv
// Shared constants for the ADC acquisition sequencer: one-hot state indices, state type, default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package adc_acq_pkg;

    localparam int NUM_STATES = 18;

    localparam int S_IDLE       = 0;
    localparam int S_WATCH      = 1;
    localparam int S_FILL_INIT1 = 2;
    localparam int S_FILL_INIT2 = 3;
    localparam int S_WFM_INIT1  = 4;
    localparam int S_WFM_INIT2  = 5;
    localparam int S_WFM_INIT3  = 6;
    localparam int S_RUN1       = 7;
    localparam int S_RUN2       = 8;
    localparam int S_RUN3       = 9;
    localparam int S_RUN4       = 10;
    localparam int S_WFM_TST1   = 11;
    localparam int S_WFM_TST2   = 12;
    localparam int S_GAP        = 13;
    localparam int S_CHECKSUM1  = 14;
    localparam int S_CHECKSUM2  = 15;
    localparam int S_DDR3_WAIT  = 16;
    localparam int S_DONE       = 17;

    localparam int DEF_SYNC_STAGES = 4;
    localparam int DEF_BURST_W     = 23;
    localparam int DEF_WFM_W       = 12;
    localparam int DEF_GAP_W       = 16;
    localparam int DEF_FILL_W      = 24;

    typedef enum logic [NUM_STATES-1:0] {
        IDLE       = 18'(1) << S_IDLE,
        WATCH      = 18'(1) << S_WATCH,
        FILL_INIT1 = 18'(1) << S_FILL_INIT1,
        FILL_INIT2 = 18'(1) << S_FILL_INIT2,
        WFM_INIT1  = 18'(1) << S_WFM_INIT1,
        WFM_INIT2  = 18'(1) << S_WFM_INIT2,
        WFM_INIT3  = 18'(1) << S_WFM_INIT3,
        RUN1       = 18'(1) << S_RUN1,
        RUN2       = 18'(1) << S_RUN2,
        RUN3       = 18'(1) << S_RUN3,
        RUN4       = 18'(1) << S_RUN4,
        WFM_TST1   = 18'(1) << S_WFM_TST1,
        WFM_TST2   = 18'(1) << S_WFM_TST2,
        GAP        = 18'(1) << S_GAP,
        CHECKSUM1  = 18'(1) << S_CHECKSUM1,
        CHECKSUM2  = 18'(1) << S_CHECKSUM2,
        DDR3_WAIT  = 18'(1) << S_DDR3_WAIT,
        DONE       = 18'(1) << S_DONE
    } state_t;

endpackage

// File: rtl/adc_acq_sync.sv
// Multi-stage flop synchroniser for asynchronous level inputs, cleared by async reset.
// Latency: STAGES clk cycles.
// Backpressure: none; levels only.
module adc_acq_sync #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES*WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[(STAGES-1)*WIDTH-1:0], d};
        end
    end

    assign q = sr[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/adc_acq_sm_multi.sv
// Multi-waveform acquisition sequencer: fill header, W x (header + B bursts, gap), checksum, DDR3 handoff.
// Latency: trigger / ddr3_wr_done to strobe SYNC_STAGES+1 clk; strobes registered from next state.
// Backpressure: none; runs free once triggered, waits only on ddr3_wr_done.
module adc_acq_sm_multi
    import adc_acq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int BURST_W     = DEF_BURST_W,
    parameter int WFM_W       = DEF_WFM_W,
    parameter int GAP_W       = DEF_GAP_W,
    parameter int FILL_W      = DEF_FILL_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         acq_enable,
    input  logic               acq_trig,
    input  logic               ddr3_wr_done,
    input  logic               dummy_dat_reset_mode,
    input  logic [BURST_W-1:0] burst_count,
    input  logic [WFM_W-1:0]   wfm_count,
    input  logic [GAP_W-1:0]   gap_count,
    output logic [1:0]         fill_type,
    output logic               address_cntr_en,
    output logic               dummy_dat_reset,
    output logic               adc_mux_fill_hdr_sel,
    output logic               adc_mux_wfm_hdr_sel,
    output logic               adc_mux_dat_sel,
    output logic               adc_mux_checksum_select,
    output logic               adc_mux_checksum_update,
    output logic               adc_acq_out_valid,
    output logic               fill_cntr_en,
    output logic               acq_done,
    output logic [WFM_W-1:0]   wfm_index,
    output logic [FILL_W-1:0]  fill_number,
    output logic               acq_enabled,
    output logic               sm_idle
);

    logic trig_s;
    logic wr_done_s;
    logic armed;

    adc_acq_sync #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync_en (
        .clk(clk), .reset_n(reset_n), .d(acq_enable), .q(fill_type)
    );
    adc_acq_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_trig (
        .clk(clk), .reset_n(reset_n), .d(acq_trig), .q(trig_s)
    );
    adc_acq_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_done (
        .clk(clk), .reset_n(reset_n), .d(ddr3_wr_done), .q(wr_done_s)
    );

    assign armed = |fill_type;

    state_t             state;
    state_t             state_nxt;
    logic [BURST_W-1:0] burst_lat;
    logic [BURST_W-1:0] burst_cnt;
    logic [WFM_W-1:0]   wfm_lat;
    logic [GAP_W-1:0]   gap_lat;
    logic [GAP_W-1:0]   gap_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (armed) state_nxt = WATCH;
            WATCH: begin
                if (trig_s)      state_nxt = FILL_INIT1;
                else if (!armed) state_nxt = IDLE;
            end
            FILL_INIT1: state_nxt = FILL_INIT2;
            FILL_INIT2: state_nxt = WFM_INIT1;
            WFM_INIT1:  state_nxt = WFM_INIT2;
            WFM_INIT2:  state_nxt = WFM_INIT3;
            WFM_INIT3:  state_nxt = RUN1;
            RUN1:       state_nxt = RUN2;
            RUN2:       state_nxt = RUN3;
            RUN3:       state_nxt = RUN4;
            RUN4:       state_nxt = (burst_cnt == '0) ? WFM_TST1 : RUN1;
            WFM_TST1:   state_nxt = WFM_TST2;
            WFM_TST2: begin
                if (wfm_index == wfm_lat) state_nxt = CHECKSUM1;
                else if (gap_lat != '0)   state_nxt = GAP;
                else                      state_nxt = WFM_INIT1;
            end
            GAP:        if (gap_cnt == '0) state_nxt = WFM_INIT1;
            CHECKSUM1:  state_nxt = CHECKSUM2;
            CHECKSUM2:  state_nxt = DDR3_WAIT;
            DDR3_WAIT:  if (wr_done_s) state_nxt = DONE;
            // Stay in DONE while the trigger is held so one long trigger yields one fill.
            DONE:       if (!trig_s || !armed) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= IDLE;
            address_cntr_en         <= 1'b0;
            dummy_dat_reset         <= 1'b0;
            adc_mux_fill_hdr_sel    <= 1'b0;
            adc_mux_wfm_hdr_sel     <= 1'b0;
            adc_mux_dat_sel         <= 1'b0;
            adc_mux_checksum_select <= 1'b0;
            adc_mux_checksum_update <= 1'b0;
            adc_acq_out_valid       <= 1'b0;
            fill_cntr_en            <= 1'b0;
            acq_done                <= 1'b0;
            acq_enabled             <= 1'b0;
            sm_idle                 <= 1'b1;
            wfm_index               <= '0;
            fill_number             <= '0;
            burst_lat               <= '0;
            burst_cnt               <= '0;
            wfm_lat                 <= '0;
            gap_lat                 <= '0;
            gap_cnt                 <= '0;
        end else begin
            state                   <= state_nxt;
            adc_mux_fill_hdr_sel    <= (state_nxt == FILL_INIT1);
            adc_acq_out_valid       <= state_nxt inside {FILL_INIT2, WFM_INIT3, RUN4, CHECKSUM2};
            address_cntr_en         <= state_nxt inside {FILL_INIT2, WFM_INIT3, RUN4, CHECKSUM2};
            dummy_dat_reset         <= (state_nxt == WFM_INIT1) && dummy_dat_reset_mode;
            adc_mux_wfm_hdr_sel     <= (state_nxt == WFM_INIT2);
            adc_mux_dat_sel         <= (state_nxt == RUN3);
            adc_mux_checksum_update <= (state_nxt == RUN3);
            adc_mux_checksum_select <= (state_nxt == CHECKSUM1);
            fill_cntr_en            <= (state_nxt == CHECKSUM2);
            acq_done                <= (state_nxt == DONE) && (state != DONE);
            acq_enabled             <= !(state_nxt inside {IDLE, WATCH});
            sm_idle                 <= (state_nxt == IDLE);

            if (state_nxt == FILL_INIT1) begin
                burst_lat <= (burst_count == '0) ? BURST_W'(1) : burst_count;
                wfm_lat   <= (wfm_count == '0) ? WFM_W'(1) : wfm_count;
                gap_lat   <= gap_count;
                wfm_index <= '0;
            end
            if (state_nxt == WFM_INIT1) burst_cnt <= burst_lat;
            if (state_nxt == RUN1)      burst_cnt <= burst_cnt - BURST_W'(1);
            if (state_nxt == WFM_TST1)  wfm_index <= wfm_index + WFM_W'(1);
            // Counter holds remaining GAP cycles after the current one; exit when it hits zero.
            if (state_nxt == GAP)       gap_cnt <= (state == GAP) ? gap_cnt - GAP_W'(1) : gap_lat - GAP_W'(1);
            if (state_nxt == CHECKSUM2) fill_number <= fill_number + FILL_W'(1);
        end
    end

endmodule

// File: tb/tb_adc_acq_sm_multi.sv
// Bench for adc_acq_sm_multi: random and directed fills compared cycle by cycle with a strobe-trace model.
// The model expands the fill rules (header, W x (header + B bursts + gap), checksum) into an expected trace.
module tb_adc_acq_sm_multi;

    localparam int SYNC = 4;
    localparam int BW   = 23;
    localparam int WW   = 12;
    localparam int GW   = 16;
    localparam int FW   = 24;

    localparam int B_IDLE  = 0;
    localparam int B_EN    = 1;
    localparam int B_DUMMY = 2;
    localparam int B_FHDR  = 3;
    localparam int B_WHDR  = 4;
    localparam int B_DAT   = 5;
    localparam int B_CSEL  = 6;
    localparam int B_CUPD  = 7;
    localparam int B_VALID = 8;
    localparam int B_ADDR  = 9;
    localparam int B_FCNT  = 10;
    localparam int B_DONE  = 11;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    acq_enable;
    logic          acq_trig;
    logic          ddr3_wr_done;
    logic          dummy_dat_reset_mode;
    logic [BW-1:0] burst_count;
    logic [WW-1:0] wfm_count;
    logic [GW-1:0] gap_count;
    logic [1:0]    fill_type;
    logic          address_cntr_en;
    logic          dummy_dat_reset;
    logic          adc_mux_fill_hdr_sel;
    logic          adc_mux_wfm_hdr_sel;
    logic          adc_mux_dat_sel;
    logic          adc_mux_checksum_select;
    logic          adc_mux_checksum_update;
    logic          adc_acq_out_valid;
    logic          fill_cntr_en;
    logic          acq_done;
    logic [WW-1:0] wfm_index;
    logic [FW-1:0] fill_number;
    logic          acq_enabled;
    logic          sm_idle;

    int n_chk = 0;
    int n_err = 0;
    int fills = 0;

    logic [11:0] exp_q[$];
    int          exp_idx[$];

    adc_acq_sm_multi #(
        .SYNC_STAGES(SYNC), .BURST_W(BW), .WFM_W(WW), .GAP_W(GW), .FILL_W(FW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .acq_enable(acq_enable),
        .acq_trig(acq_trig),
        .ddr3_wr_done(ddr3_wr_done),
        .dummy_dat_reset_mode(dummy_dat_reset_mode),
        .burst_count(burst_count),
        .wfm_count(wfm_count),
        .gap_count(gap_count),
        .fill_type(fill_type),
        .address_cntr_en(address_cntr_en),
        .dummy_dat_reset(dummy_dat_reset),
        .adc_mux_fill_hdr_sel(adc_mux_fill_hdr_sel),
        .adc_mux_wfm_hdr_sel(adc_mux_wfm_hdr_sel),
        .adc_mux_dat_sel(adc_mux_dat_sel),
        .adc_mux_checksum_select(adc_mux_checksum_select),
        .adc_mux_checksum_update(adc_mux_checksum_update),
        .adc_acq_out_valid(adc_acq_out_valid),
        .fill_cntr_en(fill_cntr_en),
        .acq_done(acq_done),
        .wfm_index(wfm_index),
        .fill_number(fill_number),
        .acq_enabled(acq_enabled),
        .sm_idle(sm_idle)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] bv(input int p);
        logic [11:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [11:0] obs();
        return {acq_done, fill_cntr_en, address_cntr_en, adc_acq_out_valid,
                adc_mux_checksum_update, adc_mux_checksum_select, adc_mux_dat_sel,
                adc_mux_wfm_hdr_sel, adc_mux_fill_hdr_sel, dummy_dat_reset, acq_enabled, sm_idle};
    endfunction

    function automatic void push(input logic [11:0] v, input int ix);
        exp_q.push_back(v);
        exp_idx.push_back(ix);
    endfunction

    // Expected per-cycle strobes from the fill-header cycle through the checksum word.
    task automatic build(input int b, input int w, input int g, input logic mode);
        logic [11:0] busy, wr;
        int be, we;
        be   = (b == 0) ? 1 : b;
        we   = (w == 0) ? 1 : w;
        busy = bv(B_EN);
        wr   = busy | bv(B_VALID) | bv(B_ADDR);
        exp_q.delete();
        exp_idx.delete();
        push(busy | bv(B_FHDR), -1);
        push(wr, -1);
        for (int wi = 0; wi < we; wi++) begin
            push(mode ? (busy | bv(B_DUMMY)) : busy, -1);
            push(busy | bv(B_WHDR), wi);
            push(wr, -1);
            for (int bi = 0; bi < be; bi++) begin
                push(busy, -1);
                push(busy, -1);
                push(busy | bv(B_DAT) | bv(B_CUPD), -1);
                push(wr, -1);
            end
            push(busy, -1);
            push(busy, -1);
            if (wi != we - 1)
                for (int gi = 0; gi < g; gi++) push(busy, -1);
        end
        push(busy | bv(B_CSEL), -1);
        push(wr | bv(B_FCNT), -1);
    endtask

    task automatic run_fill(input int b, input int w, input int g, input logic mode,
                            input int disarm_at, input int rst_at, input logic hold);
        int lat, nv, nd, be, we;
        logic [1:0] en;
        be = (b == 0) ? 1 : b;
        we = (w == 0) ? 1 : w;
        build(b, w, g, mode);
        burst_count          = BW'(b);
        wfm_count            = WW'(w);
        gap_count            = GW'(g);
        dummy_dat_reset_mode = mode;
        en                   = 2'($urandom_range(1, 3));
        acq_enable           = en;
        repeat (SYNC + 3) @(negedge clk);
        chk("fill_type", 32'(fill_type), 32'(en));
        chk("watch_vec", 32'(obs()), 32'h0);
        acq_trig = 1'b1;
        lat = 0;
        while (!adc_mux_fill_hdr_sel && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("trig_lat", lat, SYNC + 1);
        if (lat >= 50) return;

        nv = 0;
        nd = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            if (i == 2 && !hold) acq_trig = 1'b0;
            if (i == disarm_at) acq_enable = 2'b00;
            if (i == rst_at) begin
                #1 reset_n = 1'b0;
                #1;
                chk("rst_vec", 32'(obs()), 32'(bv(B_IDLE)));
                chk("rst_fill_number", 32'(fill_number), 0);
                chk("rst_wfm_index", 32'(wfm_index), 0);
                fills    = 0;
                acq_trig = 1'b0;
                return;
            end
            chk($sformatf("trace[%0d]", i), 32'(obs()), 32'(exp_q[i]));
            if (exp_idx[i] >= 0) chk($sformatf("wfm_index[%0d]", i), 32'(wfm_index), exp_idx[i]);
            nv += int'(adc_acq_out_valid);
            nd += int'(adc_mux_dat_sel);
        end
        chk("n_out_valid", nv, 2 + we * (1 + be));
        chk("n_dat_sel", nd, we * be);

        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("ddr3_wait_vec", 32'(obs()), 32'(bv(B_EN)));
        end
        ddr3_wr_done = 1'b1;
        lat = 0;
        while (!acq_done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("done_lat", lat, SYNC + 1);
        fills++;
        chk("done_vec", 32'(obs()), 32'(bv(B_EN) | bv(B_DONE)));
        chk("fill_number", 32'(fill_number), fills % (1 << FW));
        ddr3_wr_done = 1'b0;
        if (hold) begin
            repeat (20) begin
                @(negedge clk);
                chk("hold_vec", 32'(obs()), 32'(bv(B_EN)));
            end
            acq_trig = 1'b0;
        end
        lat = 0;
        while (acq_enabled && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("exit_lat", lat, hold ? SYNC + 1 : 1);
    endtask

    initial begin
        reset_n              = 1'b0;
        acq_enable           = 2'b00;
        acq_trig             = 1'b0;
        ddr3_wr_done         = 1'b0;
        dummy_dat_reset_mode = 1'b0;
        burst_count          = '0;
        wfm_count            = '0;
        gap_count            = '0;
        repeat (3) @(negedge clk);
        chk("reset_vec", 32'(obs()), 32'(bv(B_IDLE)));
        chk("reset_fill_number", 32'(fill_number), 0);
        chk("reset_wfm_index", 32'(wfm_index), 0);
        chk("reset_fill_type", 32'(fill_type), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_fill(3, 2, 5, 1'b0, -1, -1, 1'b0);
        run_fill(0, 0, 0, 1'b0, -1, -1, 1'b0);
        run_fill(2, 4, 1, 1'b1, -1, -1, 1'b0);

        // Disarm in RUN2 of the second waveform: 2 + 14 + 3 + 1.
        run_fill(2, 3, 1, 1'b0, 20, -1, 1'b0);
        repeat (5) @(negedge clk);
        chk("disarm_idle", 32'(sm_idle), 1);
        chk("disarm_fill_type", 32'(fill_type), 0);

        for (int k = 0; k < 6; k++)
            run_fill($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 6),
                     1'($urandom_range(0, 1)), -1, -1, 1'b0);

        // Reset in the third GAP cycle of the first gap.
        run_fill(3, 2, 5, 1'b0, -1, 7 + 4 * 3 + 2, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(obs() & ~bv(B_IDLE)), 0);
        end

        run_fill(1, 1, 0, 1'b0, -1, -1, 1'b1);
        run_fill(2, 2, 3, 1'b0, -1, -1, 1'b0);
        chk("second_fill_number", 32'(fill_number), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
